// File: rtl/rvj1_dmem_pkg.sv
// Shared types and helpers for the rvj1 data memory slave.
// Holds the bus widths, the response record and the FSM state encoding.
package rvj1_dmem_pkg;

    localparam int XLEN   = 32;
    localparam int NBYTES = XLEN / 8;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            error;
    } dmem_rsp_t;

    typedef enum logic [0:0] {
        eIDLE = 1'b0,
        eWAIT = 1'b1
    } dmem_state_e;

    // Replace the strobed bytes of old_word with the matching bytes of new_word.
    function automatic logic [XLEN-1:0] merge_bytes(
        input logic [XLEN-1:0]   old_word,
        input logic [XLEN-1:0]   new_word,
        input logic [NBYTES-1:0] strobe
    );
        logic [XLEN-1:0] result;
        result = old_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (strobe[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rvj1_sync_fifo.sv
// First-word-fall-through synchronous FIFO; when empty, a push is visible on
// pop_data in the same cycle and may be popped straight through.
module rvj1_sync_fifo #(
    parameter int WORD_WIDTH = 33,
    parameter int DEPTH      = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WORD_WIDTH-1:0]          push_data,
    input  logic                           pop,
    output logic [WORD_WIDTH-1:0]          pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WORD_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]         rd_ptr_r;
    logic [AW-1:0]         wr_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  bypass_s;
    logic                  wr_en_s;
    logic                  rd_en_s;

    assign empty    = (count_r == {CW{1'b0}});
    assign full     = (count_r == CW'(DEPTH));
    assign count    = count_r;
    assign pop_data = empty ? push_data : mem_r[rd_ptr_r];

    // A full FIFO may push while popping: the freed head slot is the write slot.
    assign bypass_s = empty && push && pop;
    assign wr_en_s  = push && (!full || pop) && !bypass_s;
    assign rd_en_s  = pop && !empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array, not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/rvj1_dmem.sv
// Data memory slave behind the load-store unit: word RAM with byte strobes,
// optional wait states, range/alignment error checks and a response queue.
module rvj1_dmem
    import rvj1_dmem_pkg::*;
#(
    parameter int              MEM_WORDS   = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int              WAIT_CYCLES = 0,
    parameter int              RSP_DEPTH   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [XLEN-1:0]   data_req_addr_i,
    input  logic [XLEN-1:0]   data_req_data_i,
    input  logic [NBYTES-1:0] data_req_strobe_i,
    input  logic              data_req_write_i,
    input  logic              data_req_valid_i,
    output logic              data_req_ready_o,
    output logic [XLEN-1:0]   data_rsp_data_o,
    output logic              data_rsp_error_o,
    output logic              data_rsp_valid_o,
    input  logic              data_rsp_ready_i
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("rvj1_dmem: WAIT_CYCLES must be in 0..15");
    end
    if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rvj1_dmem: RSP_DEPTH must be a power of two >= 2");
    end
    if (MEM_WORDS < 4 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
        $error("rvj1_dmem: MEM_WORDS must be a power of two >= 4");
    end

    logic [XLEN-1:0]   mem_r [MEM_WORDS];
    dmem_state_e       state_r, state_s;
    logic [3:0]        wait_cnt_r, wait_cnt_s;
    logic              run_r;
    logic              lat_load_s;
    logic [IW-1:0]     lat_idx_r;
    logic [XLEN-1:0]   lat_data_r;
    logic [NBYTES-1:0] lat_strobe_r;
    logic              lat_write_r;
    logic              lat_err_r;
    logic              pend_valid_r;
    dmem_rsp_t         pend_rsp_r;
    dmem_rsp_t         acc_rsp_s;
    dmem_rsp_t         head_rsp_s;
    logic              req_fire_s;
    logic              req_err_s;
    logic [IW-1:0]     req_idx_s;
    logic              acc_s;
    logic [IW-1:0]     acc_idx_s;
    logic [XLEN-1:0]   acc_data_s;
    logic [NBYTES-1:0] acc_strobe_s;
    logic              acc_write_s;
    logic              acc_err_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CW-1:0]     fifo_count_s;
    logic [CW:0]       occ_s;

    // BASE_ADDR is aligned to the region size, so the upper bits select the region.
    assign req_err_s  = (data_req_addr_i[1:0] != 2'b00) ||
                        (data_req_addr_i[XLEN-1:IW+2] != BASE_ADDR[XLEN-1:IW+2]);
    assign req_idx_s  = data_req_addr_i[IW+1:2];

    // run_r keeps ready low while reset is held and for the first edge after it.
    assign occ_s            = {1'b0, fifo_count_s} + {{CW{1'b0}}, pend_valid_r};
    assign data_req_ready_o = run_r && (state_r == eIDLE) && !fifo_full_s &&
                              (occ_s < (CW+1)'(RSP_DEPTH));
    assign req_fire_s       = data_req_valid_i && data_req_ready_o;

    assign acc_idx_s    = (state_r == eWAIT) ? lat_idx_r    : req_idx_s;
    assign acc_data_s   = (state_r == eWAIT) ? lat_data_r   : data_req_data_i;
    assign acc_strobe_s = (state_r == eWAIT) ? lat_strobe_r : data_req_strobe_i;
    assign acc_write_s  = (state_r == eWAIT) ? lat_write_r  : data_req_write_i;
    assign acc_err_s    = (state_r == eWAIT) ? lat_err_r    : req_err_s;

    // Next-state logic: decide when the RAM is accessed and when to latch a request.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        acc_s      = 1'b0;
        lat_load_s = 1'b0;
        case (state_r)
            eIDLE: begin
                if (req_fire_s && (WAIT_CYCLES == 0)) begin
                    acc_s = 1'b1;
                end else if (req_fire_s) begin
                    lat_load_s = 1'b1;
                    wait_cnt_s = 4'(WAIT_CYCLES);
                    state_s    = eWAIT;
                end else begin
                    state_s = eIDLE;
                end
            end
            eWAIT: begin
                wait_cnt_s = wait_cnt_r - 4'd1;
                if (wait_cnt_r == 4'd1) begin
                    acc_s   = 1'b1;
                    state_s = eIDLE;
                end else begin
                    state_s = eWAIT;
                end
            end
            default: begin
                state_s = eIDLE;
            end
        endcase
    end

    // Response formed at access time; writes and errors return zero data.
    always_comb begin
        acc_rsp_s.data  = {XLEN{1'b0}};
        acc_rsp_s.error = 1'b0;
        if (acc_err_s) begin
            acc_rsp_s.error = 1'b1;
        end else if (!acc_write_s) begin
            acc_rsp_s.data = mem_r[acc_idx_s];
        end else begin
            acc_rsp_s.data = {XLEN{1'b0}};
        end
    end

    // Control state, latched request and the single-entry pending response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= eIDLE;
            wait_cnt_r   <= 4'd0;
            run_r        <= 1'b0;
            lat_idx_r    <= {IW{1'b0}};
            lat_data_r   <= {XLEN{1'b0}};
            lat_strobe_r <= {NBYTES{1'b0}};
            lat_write_r  <= 1'b0;
            lat_err_r    <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_rsp_r   <= {$bits(dmem_rsp_t){1'b0}};
        end else begin
            state_r      <= state_s;
            wait_cnt_r   <= wait_cnt_s;
            run_r        <= 1'b1;
            pend_valid_r <= acc_s;
            if (acc_s) begin
                pend_rsp_r <= acc_rsp_s;
            end
            if (lat_load_s) begin
                lat_idx_r    <= req_idx_s;
                lat_data_r   <= data_req_data_i;
                lat_strobe_r <= data_req_strobe_i;
                lat_write_r  <= data_req_write_i;
                lat_err_r    <= req_err_s;
            end
        end
    end

    // RAM array; reset never reaches it, and acc_s is idle while reset is held.
    always_ff @(posedge clk_i) begin
        if (acc_s && acc_write_s && !acc_err_s) begin
            mem_r[acc_idx_s] <= merge_bytes(mem_r[acc_idx_s], acc_data_s, acc_strobe_s);
        end
    end

    rvj1_sync_fifo #(
        .WORD_WIDTH ($bits(dmem_rsp_t)),
        .DEPTH      (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (pend_valid_r),
        .push_data (pend_rsp_r),
        .pop       (data_rsp_ready_i),
        .pop_data  (head_rsp_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign data_rsp_valid_o = !fifo_empty_s || pend_valid_r;
    assign data_rsp_data_o  = head_rsp_s.data;
    assign data_rsp_error_o = head_rsp_s.error;

endmodule

// File: tb/tb_rvj1_dmem.sv
// Directed bench for rvj1_dmem: instance A uses zero wait states and a
// 2-deep response queue, instance B uses 3 wait states and a 4-deep queue.
module tb_rvj1_dmem;

    logic        clk = 1'b0;
    logic        rst;
    int          errors = 0;
    int          checks = 0;

    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_strb;
    logic        a_we, a_valid, a_ready, a_err, a_rvalid, a_rready;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_strb;
    logic        b_we, b_valid, b_ready, b_err, b_rvalid, b_rready;

    always #5 clk = ~clk;

    rvj1_dmem #(.MEM_WORDS(1024), .BASE_ADDR(32'h8000_0000), .WAIT_CYCLES(0), .RSP_DEPTH(2)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .data_req_addr_i(a_addr), .data_req_data_i(a_wdata), .data_req_strobe_i(a_strb),
        .data_req_write_i(a_we), .data_req_valid_i(a_valid), .data_req_ready_o(a_ready),
        .data_rsp_data_o(a_rdata), .data_rsp_error_o(a_err), .data_rsp_valid_o(a_rvalid),
        .data_rsp_ready_i(a_rready)
    );

    rvj1_dmem #(.MEM_WORDS(1024), .BASE_ADDR(32'h8000_0000), .WAIT_CYCLES(3), .RSP_DEPTH(4)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .data_req_addr_i(b_addr), .data_req_data_i(b_wdata), .data_req_strobe_i(b_strb),
        .data_req_write_i(b_we), .data_req_valid_i(b_valid), .data_req_ready_o(b_ready),
        .data_rsp_data_o(b_rdata), .data_rsp_error_o(b_err), .data_rsp_valid_o(b_rvalid),
        .data_rsp_ready_i(b_rready)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed err/data=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete zero-wait transaction on A; called #1 after a rising edge.
    task automatic a_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic we, input logic [32:0] exp);
        a_addr = addr; a_wdata = wdata; a_strb = strb; a_we = we; a_valid = 1'b1; a_rready = 1'b1;
        @(negedge clk);
        check_bit({tag, "_rdy"}, a_ready, 1'b1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(negedge clk);
        check_bit({tag, "_vld"}, a_rvalid, 1'b1);
        check_rsp({tag, "_rsp"}, {a_err, a_rdata}, exp);
        @(posedge clk); #1;
    endtask

    // Transaction on B that also checks the 3-cycle wait window.
    task automatic b_lat(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic we, input logic [32:0] exp);
        b_addr = addr; b_wdata = wdata; b_strb = strb; b_we = we; b_valid = 1'b1; b_rready = 1'b1;
        @(negedge clk);
        check_bit({tag, "_rdy"}, b_ready, 1'b1);
        @(posedge clk); #1;
        b_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check_bit($sformatf("%s_wait%0d_rdy", tag, i), b_ready, 1'b0);
            check_bit($sformatf("%s_wait%0d_vld", tag, i), b_rvalid, 1'b0);
        end
        @(negedge clk);
        check_bit({tag, "_vld"}, b_rvalid, 1'b1);
        check_rsp({tag, "_rsp"}, {b_err, b_rdata}, exp);
        check_bit({tag, "_rdy_back"}, b_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    // Issue one request on B, waiting (bounded) for ready.
    task automatic b_issue(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic we);
        int n;
        b_addr = addr; b_wdata = wdata; b_strb = strb; b_we = we; b_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!b_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_bit({tag, "_accepted"}, b_ready, 1'b1);
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    logic [31:0] fa [4];
    logic [32:0] fe [4];
    int          ki, ri;
    logic        fire;

    initial begin
        rst = 1'b1;
        a_addr = 32'h0; a_wdata = 32'h0; a_strb = 4'h0; a_we = 1'b0; a_valid = 1'b0; a_rready = 1'b0;
        b_addr = 32'h0; b_wdata = 32'h0; b_strb = 4'h0; b_we = 1'b0; b_valid = 1'b0; b_rready = 1'b0;
        repeat (2) @(negedge clk);
        check_bit("rst_a_rdy", a_ready, 1'b0);
        check_bit("rst_a_vld", a_rvalid, 1'b0);
        check_rsp("rst_a_rsp", {a_err, a_rdata}, 33'h0);
        check_bit("rst_b_rdy", b_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_bit("post_rst_a_rdy", a_ready, 1'b1);
        @(posedge clk); #1;

        // Full-word write and read-back, then strobed and no-op writes.
        a_txn("wr10", 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b1, 33'h0);
        a_txn("rd10", 32'h8000_0010, 32'h0, 4'b0000, 1'b0, {1'b0, 32'hDEAD_BEEF});
        a_txn("wr04", 32'h8000_0004, 32'h1122_3344, 4'b1111, 1'b1, 33'h0);
        a_txn("wr04b", 32'h8000_0004, 32'h0000_AA00, 4'b0010, 1'b1, 33'h0);
        a_txn("rd04b", 32'h8000_0004, 32'h0, 4'b0000, 1'b0, {1'b0, 32'h1122_AA44});
        a_txn("wr04z", 32'h8000_0004, 32'hFFFF_FFFF, 4'b0000, 1'b1, 33'h0);
        a_txn("rd04z", 32'h8000_0004, 32'h0, 4'b1111, 1'b0, {1'b0, 32'h1122_AA44});

        // Error accesses: misaligned, below base, past end; RAM must stay intact.
        a_txn("err_mis", 32'h8000_0002, 32'h0, 4'b0000, 1'b0, {1'b1, 32'h0});
        a_txn("err_low", 32'h7FFF_FFFC, 32'h0, 4'b0000, 1'b0, {1'b1, 32'h0});
        a_txn("err_high", 32'h8000_1000, 32'h0, 4'b0000, 1'b0, {1'b1, 32'h0});
        a_txn("err_wmis", 32'h8000_0006, 32'hFFFF_FFFF, 4'b1111, 1'b1, {1'b1, 32'h0});
        a_txn("err_walias", 32'h8000_1010, 32'h0, 4'b1111, 1'b1, {1'b1, 32'h0});
        a_txn("keep04", 32'h8000_0004, 32'h0, 4'b0000, 1'b0, {1'b0, 32'h1122_AA44});
        a_txn("keep10", 32'h8000_0010, 32'h0, 4'b0000, 1'b0, {1'b0, 32'hDEAD_BEEF});

        // Read in the cycle right after a write to the same word.
        a_addr = 32'h8000_0020; a_wdata = 32'hCAFE_F00D; a_strb = 4'b1111; a_we = 1'b1; a_valid = 1'b1;
        @(negedge clk);
        check_bit("raw_w_rdy", a_ready, 1'b1);
        @(posedge clk); #1;
        a_we = 1'b0; a_strb = 4'b0000;
        @(negedge clk);
        check_bit("raw_r_rdy", a_ready, 1'b1);
        check_rsp("raw_w_rsp", {a_err, a_rdata}, 33'h0);
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(negedge clk);
        check_bit("raw_r_vld", a_rvalid, 1'b1);
        check_rsp("raw_r_rsp", {a_err, a_rdata}, {1'b0, 32'hCAFE_F00D});
        @(posedge clk); #1;

        // Back-pressure: 4 back-to-back reads into a 2-deep queue.
        fa[0] = 32'h8000_0010; fe[0] = {1'b0, 32'hDEAD_BEEF};
        fa[1] = 32'h8000_0004; fe[1] = {1'b0, 32'h1122_AA44};
        fa[2] = 32'h8000_0020; fe[2] = {1'b0, 32'hCAFE_F00D};
        fa[3] = 32'h8000_0002; fe[3] = {1'b1, 32'h0};
        a_rready = 1'b0; a_we = 1'b0; a_strb = 4'b0000;
        ki = 0; ri = 0;
        a_addr = fa[0]; a_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_bit($sformatf("full_acc%0d", k), a_ready, 1'b1);
            @(posedge clk); #1;
            ki++;
            a_addr = fa[ki];
        end
        @(negedge clk);
        check_bit("full_rdy_low", a_ready, 1'b0);
        check_bit("full_head_vld", a_rvalid, 1'b1);
        check_rsp("full_head", {a_err, a_rdata}, fe[0]);
        @(posedge clk); #1;
        @(negedge clk);
        check_bit("full_still_low", a_ready, 1'b0);
        check_rsp("full_hold", {a_err, a_rdata}, fe[0]);
        @(posedge clk); #1;
        a_rready = 1'b1;
        @(negedge clk);
        check_bit("full_rdy_at_pop", a_ready, 1'b0);
        check_rsp("full_rsp0", {a_err, a_rdata}, fe[0]);
        ri = 1;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 40 && ri < 4; cyc++) begin
            @(negedge clk);
            fire = a_valid && a_ready;
            if (cyc == 0) begin
                check_bit("full_rdy_rise", a_ready, 1'b1);
            end
            if (a_rvalid) begin
                check_rsp($sformatf("full_rsp%0d", ri), {a_err, a_rdata}, fe[ri]);
                ri++;
            end
            @(posedge clk); #1;
            if (fire) begin
                ki++;
                if (ki < 4) a_addr = fa[ki];
                else a_valid = 1'b0;
            end
        end
        check_rsp("full_rsp_count", 33'(ri), 33'd4);
        check_rsp("full_req_count", 33'(ki), 33'd4);
        @(negedge clk);
        check_bit("full_drained", a_rvalid, 1'b0);
        @(posedge clk); #1;

        // Wait-state latency on B.
        b_lat("b_wr", 32'h8000_0010, 32'h1234_5678, 4'b1111, 1'b1, 33'h0);
        b_lat("b_rd", 32'h8000_0010, 32'h0, 4'b0000, 1'b0, {1'b0, 32'h1234_5678});

        // Reset while a write waits in eWAIT behind two queued responses.
        b_rready = 1'b0;
        b_issue("q0", 32'h8000_0010, 32'h0, 4'b0000, 1'b0);
        b_issue("q1", 32'h8000_0010, 32'h0, 4'b0000, 1'b0);
        b_issue("qw", 32'h8000_0010, 32'hBAD0_BAD0, 4'b1111, 1'b1);
        @(negedge clk);
        check_bit("pre_rst_vld", b_rvalid, 1'b1);
        check_bit("pre_rst_rdy", b_ready, 1'b0);
        rst = 1'b1;
        #1;
        check_bit("in_rst_b_vld", b_rvalid, 1'b0);
        check_bit("in_rst_b_rdy", b_ready, 1'b0);
        check_rsp("in_rst_b_rsp", {b_err, b_rdata}, 33'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_bit($sformatf("post_rst_stale%0d", i), b_rvalid, 1'b0);
        end
        check_bit("post_rst_b_rdy", b_ready, 1'b1);
        @(posedge clk); #1;
        b_lat("b_after_rst", 32'h8000_0010, 32'h0, 4'b0000, 1'b0, {1'b0, 32'h1234_5678});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
